// File: rtl/execute_if.sv
// ----------------------------------------------------------------------------
// execute_if
//   Decode-to-execute bundle plus the execute stage outputs.
//   master : decode side (drives the instruction bundle, sees stall/result)
//   slave  : execute stage
//   Signals:
//     in_valid, flush              bundle valid / kill instruction in EX
//     rs1_data, rs2_data, imm, pc  operands, immediate, instruction PC
//     alu_op, alu_src_imm          operation select, operand-B select
//     rd, write_en, ctrl_in        destination, write enable, forwarded control
//     stall                        hold IF/ID and keep the bundle stable
//     exc_mem_reg                  {rd, write_en, ctrl, alu_out, rs2_data, pc+4}
// ----------------------------------------------------------------------------
interface execute_if #(
   parameter int REG_WIDTH = 32,
   parameter int REG_COUNT = 32,
   parameter int CTRL_SIZE = 21,
   parameter int REG_BITS  = $clog2(REG_COUNT)
);
   logic                                       in_valid;
   logic                                       flush;
   logic [REG_WIDTH-1:0]                       rs1_data;
   logic [REG_WIDTH-1:0]                       rs2_data;
   logic [REG_WIDTH-1:0]                       imm;
   logic [REG_WIDTH-1:0]                       pc;
   logic [4:0]                                 alu_op;
   logic                                       alu_src_imm;
   logic [REG_BITS-1:0]                        rd;
   logic                                       write_en;
   logic [CTRL_SIZE-8:0]                       ctrl_in;
   logic                                       stall;
   logic [REG_BITS+CTRL_SIZE-6+3*REG_WIDTH-1:0] exc_mem_reg;

   modport master (
      output in_valid, flush, rs1_data, rs2_data, imm, pc, alu_op, alu_src_imm,
             rd, write_en, ctrl_in,
      input  stall, exc_mem_reg
   );

   modport slave (
      input  in_valid, flush, rs1_data, rs2_data, imm, pc, alu_op, alu_src_imm,
             rd, write_en, ctrl_in,
      output stall, exc_mem_reg
   );
endinterface

// File: rtl/execute.sv
// ----------------------------------------------------------------------------
// execute
//   Execute stage of the 5-stage RV32IM pipeline. Base RV32I ALU ops complete
//   in one cycle; M-extension ops run on an iterative radix-2 shift-add /
//   restoring-divide unit that stalls upstream and emits bubbles downstream.
//   Ports:
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset (also aborts an in-flight mul/div)
//     ex   : execute_if.slave (decode bundle in, stall and exc_mem_reg out)
//   Configuration macro:
//     EXC_FAST_MUL_EN : MUL/MULH/MULHSU/MULHU use a single-cycle combinational
//                       multiplier; DIV/REM stay iterative.
// ----------------------------------------------------------------------------
module execute #(
   parameter int REG_WIDTH = 32,
   parameter int REG_COUNT = 32,
   parameter int CTRL_SIZE = 21,
   parameter int REG_BITS  = $clog2(REG_COUNT)
) (
   input  logic     clk,
   input  logic     rst,
   execute_if.slave ex
);
   localparam int W     = REG_WIDTH;
   localparam int SH    = $clog2(W);
   localparam int CW    = $clog2(W) + 1;
   localparam int OUT_W = REG_BITS + CTRL_SIZE - 6 + 3 * W;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   function automatic logic [W-1:0] alu_base(input logic [4:0] op,
                                             input logic signed [W-1:0] a,
                                             input logic signed [W-1:0] b);
      logic [W-1:0] r;
      case (op)
         5'd0:    r = a + b;
         5'd1:    r = a - b;
         5'd2:    r = a << b[SH-1:0];
         5'd3:    r = {{(W-1){1'b0}}, (a < b)};
         5'd4:    r = {{(W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
         5'd5:    r = a ^ b;
         5'd6:    r = $unsigned(a) >> b[SH-1:0];
         5'd7:    r = a >>> b[SH-1:0];
         5'd8:    r = a | b;
         5'd9:    r = a & b;
         5'd10:   r = b;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Sign fix-up of the unsigned magnitude result. Negating the 64-bit pair
   // also yields the negated quotient in its low half.
   function automatic logic [W-1:0] md_result(input logic [2:0] op,
                                              input logic [W-1:0] hi,
                                              input logic [W-1:0] lo,
                                              input logic neg_p,
                                              input logic neg_r);
      logic [2*W-1:0] p;
      logic [W-1:0]   r;
      p = neg_p ? -{hi, lo} : {hi, lo};
      if (!op[2])      r = (op[1:0] == 2'd0) ? p[W-1:0] : p[2*W-1:W];
      else if (!op[1]) r = p[W-1:0];
      else             r = neg_r ? -hi : hi;
      return r;
   endfunction

   state_t              state;
   logic [CW-1:0]       cnt;
   logic [OUT_W-1:0]    exc_q;

   logic signed [W-1:0] op_a, op_b;
   logic [2:0]          op3;
   logic                is_md, is_iter, start;
   logic                sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
   logic [W-1:0]        mag_a, mag_b, alu_res, pc4;

   // Latched copies used while the iterative unit runs
   logic [2:0]          lat_op;
   logic [REG_BITS-1:0] lat_rd;
   logic                lat_we;
   logic [CTRL_SIZE-8:0] lat_ctrl;
   logic [W-1:0]        lat_rs2, lat_pc4;
   logic [W-1:0]        acc, lo, mcand;
   logic                neg_p, neg_r;
   logic [W:0]          mul_sum, div_shift, div_diff;

   assign op_a  = ex.rs1_data;
   assign op_b  = ex.alu_src_imm ? ex.imm : ex.rs2_data;
   assign op3   = ex.alu_op[2:0];
   assign pc4   = ex.pc + W'(4);
   assign is_md = (ex.alu_op[4:3] == 2'b10);
`ifdef EXC_FAST_MUL_EN
   assign is_iter = is_md & ex.alu_op[2];
`else
   assign is_iter = is_md;
`endif
   assign start = ex.in_valid & is_iter & ~ex.flush & (state == IDLE);
   assign ex.stall = ~rst & ~ex.flush &
                     ((state == BUSY) | (state == IDLE & ex.in_valid & is_iter));
   assign ex.exc_mem_reg = exc_q;

   // MULH, MULHSU, DIV, REM treat A as signed; MULH, DIV, REM treat B as signed
   assign sgn_a    = (op3 == 3'd1) || (op3 == 3'd2) || (op3 == 3'd4) || (op3 == 3'd6);
   assign sgn_b    = (op3 == 3'd1) || (op3 == 3'd4) || (op3 == 3'd6);
   assign neg_a    = sgn_a & op_a[W-1];
   assign neg_b    = sgn_b & op_b[W-1];
   assign mag_a    = neg_a ? -op_a : op_a;
   assign mag_b    = neg_b ? -op_b : op_b;
   assign div_zero = op3[2] & (op_b == '0);
   assign div_ovf  = op3[2] & ~op3[0] & (op_a == {1'b1, {(W-1){1'b0}}}) & (op_b == '1);

`ifdef EXC_FAST_MUL_EN
   logic [2*W-1:0] ext_a, ext_b, fprod;
   assign ext_a = {{W{neg_a}}, op_a};
   assign ext_b = {{W{neg_b}}, op_b};
   assign fprod = ext_a * ext_b;
`endif

   always_comb begin
      alu_res = alu_base(ex.alu_op, op_a, op_b);
`ifdef EXC_FAST_MUL_EN
      if (is_md && !ex.alu_op[2])
         alu_res = (op3[1:0] == 2'd0) ? fprod[W-1:0] : fprod[2*W-1:W];
`endif
   end

   // One radix-2 step: shift-add for multiply, shift-subtract for divide
   assign mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, mcand} : '0);
   assign div_shift = {acc, lo[W-1]};
   assign div_diff  = div_shift - {1'b0, mcand};

   // ---- latch / iterate stage ----
   always_ff @(posedge clk) begin
      if (start) begin
         lat_op   <= op3;
         lat_rd   <= ex.rd;
         lat_we   <= ex.write_en;
         lat_ctrl <= ex.ctrl_in;
         lat_rs2  <= ex.rs2_data;
         lat_pc4  <= pc4;
         mcand    <= mag_b;
         if (div_zero) begin
            acc   <= op_a;
            lo    <= '1;
            neg_p <= 1'b0;
            neg_r <= 1'b0;
         end else if (div_ovf) begin
            acc   <= '0;
            lo    <= {1'b1, {(W-1){1'b0}}};
            neg_p <= 1'b0;
            neg_r <= 1'b0;
         end else begin
            acc   <= '0;
            lo    <= mag_a;
            neg_p <= neg_a ^ neg_b;
            neg_r <= neg_a;
         end
      end else if (state == BUSY) begin
         if (!lat_op[2]) begin
            acc <= mul_sum[W:1];
            lo  <= {mul_sum[0], lo[W-1:1]};
         end else begin
            acc <= div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
            lo  <= {lo[W-2:0], ~div_diff[W]};
         end
      end
   end

   // ---- EX/MEM register and control FSM ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         exc_q <= '0;
      end else if (ex.flush) begin
         state <= IDLE;
         cnt   <= '0;
         exc_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= (div_zero | div_ovf) ? DONE : BUSY;
                  cnt   <= CW'(W);
                  exc_q <= '0;
               end else if (ex.in_valid) begin
                  exc_q <= {ex.rd, ex.write_en, ex.ctrl_in, alu_res, ex.rs2_data, pc4};
               end else begin
                  exc_q <= '0;
               end
            end
            BUSY: begin
               cnt   <= cnt - CW'(1);
               exc_q <= '0;
               if (cnt == CW'(1)) state <= DONE;
            end
            DONE: begin
               exc_q <= {lat_rd, lat_we, lat_ctrl,
                         md_result(lat_op, acc, lo, neg_p, neg_r), lat_rs2, lat_pc4};
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_execute.sv
module tb_execute;
   localparam int W  = 32;
   localparam int RB = 5;
   localparam int CS = 21;
   localparam int OW = RB + CS - 6 + 3 * W;
`ifdef EXC_FAST_MUL_EN
   localparam int MUL_STALL = 0;
`else
   localparam int MUL_STALL = 33;
`endif
   localparam int DIV_STALL = 33;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   execute_if #(.REG_WIDTH(W), .REG_COUNT(32), .CTRL_SIZE(CS)) bus ();
   execute #(.REG_WIDTH(W), .REG_COUNT(32), .CTRL_SIZE(CS)) dut (
      .clk (clk),
      .rst (rst),
      .ex  (bus)
   );

   int             total = 0;
   int             bad   = 0;
   int             seq   = 0;
   int             stale;
   logic [OW-1:0]  sb_q[$];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic present(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic fl);
      bus.alu_op      = op;
      bus.rs1_data    = a;
      bus.rs2_data    = b;
      bus.imm         = 32'h0;
      bus.alu_src_imm = 1'b0;
      bus.rd          = 5'd3;
      bus.write_en    = 1'b1;
      bus.ctrl_in     = 14'h1;
      bus.pc          = 32'h40;
      bus.flush       = fl;
      bus.in_valid    = 1'b1;
   endtask

   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic use_imm,
                         input int exp_stall, input logic [31:0] exp_alu);
      logic [4:0]  rd;
      logic [13:0] ctrl;
      logic [31:0] pc;
      int          stalls;
      int          bubbles_bad;
      logic        s;
      logic        accepted;
      seq++;
      rd   = 5'(seq) | 5'd1;
      ctrl = 14'(seq * 297);
      pc   = 32'h100 + 32'(seq * 4);
      sb_q.push_back({rd, 1'b1, ctrl, exp_alu, rs2, pc + 32'd4});
      bus.alu_op      = op;
      bus.rs1_data    = a;
      bus.rs2_data    = rs2;
      bus.imm         = imm;
      bus.alu_src_imm = use_imm;
      bus.rd          = rd;
      bus.write_en    = 1'b1;
      bus.ctrl_in     = ctrl;
      bus.pc          = pc;
      bus.flush       = 1'b0;
      bus.in_valid    = 1'b1;
      stalls      = 0;
      bubbles_bad = 0;
      accepted    = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         s = bus.stall;
         @(posedge clk);
         #1;
         if (!s) begin
            accepted = 1'b1;
            break;
         end
         stalls++;
         if (bus.exc_mem_reg !== '0) bubbles_bad++;
      end
      bus.in_valid = 1'b0;
      check({tag, "_accept"}, 128'(accepted), 128'(1));
      check({tag, "_stall"}, 128'(stalls), 128'(exp_stall));
      check({tag, "_bubbles"}, 128'(bubbles_bad), 128'(0));
      if (sb_q.size() > 0) check({tag, "_out"}, 128'(bus.exc_mem_reg), 128'(sb_q.pop_front()));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with a div op presented
      present(5'd20, 32'd100, 32'd7, 1'b0);
      rst = 1'b1;
      #2;
      check("reset_exc", 128'(bus.exc_mem_reg), 128'(0));
      check("reset_stall", 128'(bus.stall), 128'(0));
      @(posedge clk);
      #1;
      check("reset_exc_edge", 128'(bus.exc_mem_reg), 128'(0));
      bus.in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // base ALU
      run_op("add_imm",  5'd0,  32'd5,        32'h55,       32'd7,        1'b1, 0, 32'd12);
      run_op("add_wrap", 5'd0,  32'hFFFFFFFF, 32'd2,        32'd0,        1'b0, 0, 32'd1);
      run_op("sub",      5'd1,  32'd3,        32'd5,        32'd0,        1'b0, 0, 32'hFFFFFFFE);
      run_op("sll",      5'd2,  32'd1,        32'h23,       32'd0,        1'b0, 0, 32'd8);
      run_op("slt",      5'd3,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 0, 32'd0);
      run_op("sltu",     5'd4,  32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 0, 32'd1);
      run_op("xor",      5'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        1'b0, 0, 32'h0FF00FF0);
      run_op("srl",      5'd6,  32'h80000000, 32'd4,        32'd0,        1'b0, 0, 32'h08000000);
      run_op("sra",      5'd7,  32'h80000000, 32'd4,        32'd0,        1'b0, 0, 32'hF8000000);
      run_op("or",       5'd8,  32'hF0F0F0F0, 32'h0F000000, 32'd0,        1'b0, 0, 32'hFFF0F0F0);
      run_op("and",      5'd9,  32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        1'b0, 0, 32'hF000F000);
      run_op("passb",    5'd10, 32'd9,        32'h1234,     32'hDEADBEEF, 1'b1, 0, 32'hDEADBEEF);
      run_op("undef12",  5'd12, 32'd9,        32'd3,        32'd0,        1'b0, 0, 32'd0);
      run_op("undef24",  5'd24, 32'd9,        32'd3,        32'd0,        1'b0, 0, 32'd0);

      // divide / remainder
      run_op("div_m7_2",   5'd20, 32'hFFFFFFF9, 32'd2,        32'd0, 1'b0, DIV_STALL, 32'hFFFFFFFD);
      run_op("rem_m7_2",   5'd22, 32'hFFFFFFF9, 32'd2,        32'd0, 1'b0, DIV_STALL, 32'hFFFFFFFF);
      run_op("div_7_m2",   5'd20, 32'd7,        32'hFFFFFFFE, 32'd0, 1'b0, DIV_STALL, 32'hFFFFFFFD);
      run_op("rem_7_m2",   5'd22, 32'd7,        32'hFFFFFFFE, 32'd0, 1'b0, DIV_STALL, 32'd1);
      run_op("divu_100_7", 5'd21, 32'd100,      32'd7,        32'd0, 1'b0, DIV_STALL, 32'd14);
      run_op("remu_100_7", 5'd23, 32'd100,      32'd7,        32'd0, 1'b0, DIV_STALL, 32'd2);
      run_op("divu_big",   5'd21, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, DIV_STALL, 32'd0);
      run_op("divu_5_0",   5'd21, 32'd5,        32'd0,        32'd0, 1'b0, 1,         32'hFFFFFFFF);
      run_op("remu_5_0",   5'd23, 32'd5,        32'd0,        32'd0, 1'b0, 1,         32'd5);
      run_op("div_m7_0",   5'd20, 32'hFFFFFFF9, 32'd0,        32'd0, 1'b0, 1,         32'hFFFFFFFF);
      run_op("rem_m7_0",   5'd22, 32'hFFFFFFF9, 32'd0,        32'd0, 1'b0, 1,         32'hFFFFFFF9);
      run_op("div_ovf",    5'd20, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1,         32'h80000000);
      run_op("rem_ovf",    5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 1,         32'd0);

      // multiply
      run_op("mulhu_max",  5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, MUL_STALL, 32'hFFFFFFFE);
      run_op("mulh_m1",    5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, MUL_STALL, 32'd0);
      run_op("mulh_min",   5'd17, 32'h80000000, 32'h80000000, 32'd0, 1'b0, MUL_STALL, 32'h40000000);
      run_op("mul_7_m3",   5'd16, 32'd7,        32'hFFFFFFFD, 32'd0, 1'b0, MUL_STALL, 32'hFFFFFFEB);
      run_op("mul_shift",  5'd16, 32'h12345678, 32'h10,       32'd0, 1'b0, MUL_STALL, 32'h23456780);
      run_op("mulhsu_m1",  5'd18, 32'hFFFFFFFF, 32'd2,        32'd0, 1'b0, MUL_STALL, 32'hFFFFFFFF);
      run_op("mulhsu_2",   5'd18, 32'd2,        32'hFFFFFFFF, 32'd0, 1'b0, MUL_STALL, 32'd1);

      // flush in BUSY at cnt = 10
      present(5'd21, 32'd100, 32'd7, 1'b0);
      repeat (23) @(posedge clk);
      #1;
      check("flush_pre_stall", 128'(bus.stall), 128'(1));
      bus.flush = 1'b1;
      #1;
      check("flush_stall_drop", 128'(bus.stall), 128'(0));
      @(posedge clk);
      #1;
      check("flush_exc", 128'(bus.exc_mem_reg), 128'(0));
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      stale = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.exc_mem_reg !== '0) stale++;
      end
      check("flush_no_stale", 128'(stale), 128'(0));
      run_op("flush_add", 5'd0, 32'd20, 32'd22, 32'd0, 1'b0, 0, 32'd42);

      // op presented together with flush is dropped
      present(5'd0, 32'd1, 32'd1, 1'b1);
      @(posedge clk);
      #1;
      check("flush_idle_kill", 128'(bus.exc_mem_reg), 128'(0));
      present(5'd20, 32'd100, 32'd7, 1'b1);
      #1;
      check("flush_md_stall", 128'(bus.stall), 128'(0));
      @(posedge clk);
      #1;
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      stale = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.exc_mem_reg !== '0 || bus.stall !== 1'b0) stale++;
      end
      check("flush_md_no_exec", 128'(stale), 128'(0));

      // asynchronous reset in BUSY at cnt = 17
      present(5'd21, 32'd100, 32'd7, 1'b0);
      repeat (16) @(posedge clk);
      #1;
      check("rst_pre_stall", 128'(bus.stall), 128'(1));
      rst = 1'b1;
      #1;
      check("rst_mid_stall", 128'(bus.stall), 128'(0));
      check("rst_mid_exc", 128'(bus.exc_mem_reg), 128'(0));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rst = 1'b0;
      stale = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.exc_mem_reg !== '0 || bus.stall !== 1'b0) stale++;
      end
      check("rst_no_stale", 128'(stale), 128'(0));
      run_op("rst_add", 5'd0, 32'd5, 32'd7, 32'd0, 1'b0, 0, 32'd12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
